// File: rtl/lsu_mem_stage_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage_if
// Groups the three handshakes of the load/store memory stage into one bundle:
//   request  : req_valid/req_ready, req_we, req_funct3, req_addr, req_wdata
//   bus      : busReq, busWe, busAddr, busBE, busWData, busRData, busReady
//   response : rsp_valid, rsp_rdata, rsp_err
// Modports:
//   master : the LSU itself (drives bus requests, the response and req_ready)
//   slave  : its environment (control unit issuing requests plus the memory)
// Parameter XLEN must match the XLEN of the lsu_mem_stage it connects to.
// -----------------------------------------------------------------------------
interface lsu_mem_stage_if #(
    parameter int XLEN = 32
);
    localparam int NB = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            busReq;
    logic            busWe;
    logic [XLEN-1:0] busAddr;
    logic [NB-1:0]   busBE;
    logic [XLEN-1:0] busWData;
    logic [XLEN-1:0] busRData;
    logic            busReady;

    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic [1:0]      rsp_err;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  busRData, busReady,
        output req_ready,
        output busReq, busWe, busAddr, busBE, busWData,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output busRData, busReady,
        input  req_ready,
        input  busReq, busWe, busAddr, busBE, busWData,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
// Load/store unit for the memory-access step of a multi-cycle RV core.
// Accepts one request, decodes size/alignment, drives a lane-aligned bus
// transaction that tolerates wait states, extends load data and returns a
// one-cycle response with an error code (00 ok, 01 misaligned, 10 timeout,
// 11 illegal funct3).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : lsu_mem_stage_if.master (request, memory bus and response)
// Parameters:
//   XLEN           : 32 or 64
//   TIMEOUT_CYCLES : ACCESS cycles without busReady before err=10 (2..255)
// Optional feature macro LSU_TIMEOUT_EN: when defined the ACCESS timeout
// counter is built; when undefined ACCESS waits for busReady indefinitely.
// -----------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    lsu_mem_stage_if.master bus
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_TO  = 2'b10;
    localparam logic [1:0] ERR_ILL = 2'b11;

    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("lsu_mem_stage: XLEN must be 32 or 64");
    end
    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("lsu_mem_stage: TIMEOUT_CYCLES must be within 2..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic            req_ready_q, req_ready_d;
    logic            bus_req_q,   bus_req_d;
    logic            bus_we_q,    bus_we_d;
    logic [XLEN-1:0] bus_addr_q,  bus_addr_d;
    logic [NB-1:0]   bus_be_q,    bus_be_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_err_q,   rsp_err_d;
    // Access shape kept for the load-data extraction in ACCESS.
    logic [OFFW-1:0] off_q,       off_d;
    logic [1:0]      size_q,      size_d;
    logic            uns_q,       uns_d;
`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]      cnt_q,       cnt_d;
`endif

    logic [OFFW-1:0] req_off_s;
    logic [1:0]      req_size_s;
    logic            req_legal_s;
    logic            req_mis_s;
    logic [3:0]      align_s;
    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] dmask_s;
    logic            sign_s;
    logic [XLEN-1:0] load_data_s;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        logic [3:0] n;
        case (sz)
            2'd0:    n = 4'd1;
            2'd1:    n = 4'd2;
            2'd2:    n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) begin
            m[i] = (i < int'(size_bytes(sz)));
        end
        return m;
    endfunction

    function automatic logic [XLEN-1:0] data_mask(input logic [1:0] sz);
        logic [XLEN-1:0] m;
        for (int i = 0; i < NB; i++) begin
            m[8*i +: 8] = {8{(i < int'(size_bytes(sz)))}};
        end
        return m;
    endfunction

    // Double and WU only exist on RV64; unsigned (1xx) codes are load-only.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic we);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b011:                 ok = (XLEN == 64);
            3'b100, 3'b101:         ok = ~we;
            3'b110:                 ok = ~we & (XLEN == 64);
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Request decode: lane offset, size, legality and alignment.
    always_comb begin
        req_off_s   = bus.req_addr[OFFW-1:0];
        req_size_s  = bus.req_funct3[1:0];
        req_legal_s = funct3_legal(bus.req_funct3, bus.req_we);
        align_s     = size_bytes(req_size_s) - 4'd1;
        req_mis_s   = |(req_off_s & align_s[OFFW-1:0]);
    end

    // Load path: bring the addressed lane down to bit 0, then sign/zero extend.
    always_comb begin
        shifted_s = bus.busRData >> {off_q, 3'b000};
        dmask_s   = data_mask(size_q);
        case (size_q)
            2'd0:    sign_s = shifted_s[7];
            2'd1:    sign_s = shifted_s[15];
            2'd2:    sign_s = shifted_s[31];
            default: sign_s = shifted_s[XLEN-1];
        endcase
        load_data_s = (shifted_s & dmask_s) | ({XLEN{sign_s & ~uns_q}} & ~dmask_s);
    end

    // Next-state and next-output logic of the IDLE/ACCESS/RESP controller.
    always_comb begin
        state_d     = state_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    off_d  = req_off_s;
                    size_d = req_size_s;
                    uns_d  = bus.req_funct3[2];
                    if (!req_legal_s) begin
                        state_d     = RESP;
                        rsp_err_d   = ERR_ILL;
                        rsp_rdata_d = {XLEN{1'b0}};
                    end else if (req_mis_s) begin
                        state_d     = RESP;
                        rsp_err_d   = ERR_MIS;
                        rsp_rdata_d = {XLEN{1'b0}};
                    end else begin
                        state_d     = ACCESS;
                        bus_we_d    = bus.req_we;
                        bus_addr_d  = {bus.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                        bus_be_d    = lane_mask(req_size_s) << req_off_s;
                        if (bus.req_we) begin
                            bus_wdata_d = (bus.req_wdata & data_mask(req_size_s)) << {req_off_s, 3'b000};
                        end else begin
                            bus_wdata_d = {XLEN{1'b0}};
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (bus.busReady) begin
                    state_d   = RESP;
                    rsp_err_d = ERR_OK;
                    if (bus_we_q) begin
                        rsp_rdata_d = {XLEN{1'b0}};
                    end else begin
                        rsp_rdata_d = load_data_s;
                    end
                end else begin
`ifdef LSU_TIMEOUT_EN
                    // cnt_q counts wait cycles already spent; this one is the last allowed.
                    if (cnt_q == TO_LAST) begin
                        state_d     = RESP;
                        rsp_err_d   = ERR_TO;
                        rsp_rdata_d = {XLEN{1'b0}};
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`else
                    state_d = ACCESS;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
`ifdef LSU_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status outputs are registered copies of the state being entered.
        req_ready_d = (state_d == IDLE);
        bus_req_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= {XLEN{1'b0}};
            bus_be_q    <= {NB{1'b0}};
            bus_wdata_q <= {XLEN{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {XLEN{1'b0}};
            rsp_err_q   <= 2'b00;
            off_q       <= {OFFW{1'b0}};
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.busReq    = bus_req_q;
    assign bus.busWe     = bus_we_q;
    assign bus.busAddr   = bus_addr_q;
    assign bus.busBE     = bus_be_q;
    assign bus.busWData  = bus_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_stage
// Scoreboard bench for lsu_mem_stage (XLEN=32, TIMEOUT_CYCLES=16). The driver
// computes each request's expected bus beat and response from the RISC-V
// load/store rules using byte loops and integer arithmetic and queues them; a
// bus responder and a response monitor pop and compare independently.
// -----------------------------------------------------------------------------
module tb_lsu_mem_stage;
    logic clk = 1'b0;
    logic reset;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   run    = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          accept;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        int          waits;
        logic [31:0] rd;
        int          len;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];

    lsu_mem_stage_if #(.XLEN(32)) bif ();

    lsu_mem_stage #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference load: gather bytes, then sign-extend arithmetically.
    function automatic logic [31:0] model_load(input logic [31:0] rd, input int off,
                                               input int n, input bit uns);
        longint v;
        v = 0;
        for (int i = 0; i < n; i++) begin
            v += longint'((rd >> (8 * (off + i))) & 32'hFF) << (8 * i);
        end
        if (!uns && v >= (64'sd1 <<< (8 * n - 1))) v -= (64'sd1 <<< (8 * n));
        return v[31:0];
    endfunction

    // Memory side: checks the held bus beat, inserts wait states, measures busReq length.
    always @(negedge clk) begin
        if (!reset) begin
            run = 0;
            bif.busReady = 1'b0;
            bif.busRData = 32'h0;
        end else if (bif.busReq) begin
            if (bus_q.size() == 0) begin
                fail_now("unexpected_busReq");
                bif.busReady = 1'b0;
            end else begin
                check("busAddr",  bif.busAddr,  bus_q[0].addr);
                check("busBE",    bif.busBE,    bus_q[0].be);
                check("busWData", bif.busWData, bus_q[0].wdata);
                check("busWe",    bif.busWe,    bus_q[0].we);
                if (run == bus_q[0].waits) begin
                    bif.busReady = 1'b1;
                    bif.busRData = bus_q[0].rd;
                end else begin
                    bif.busReady = 1'b0;
                    bif.busRData = $urandom;
                end
                run++;
            end
        end else begin
            // busReady outside ACCESS must be ignored, so toggle it freely here.
            bif.busReady = 1'($urandom_range(0, 1));
            bif.busRData = $urandom;
            if (run > 0) begin
                if (bus_q.size() != 0) begin
                    check("busReq_cycles", run, bus_q[0].len);
                    void'(bus_q.pop_front());
                end
                run = 0;
            end
        end
    end

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        rsp_t e;
        if (reset && bif.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                fail_now("unexpected_rsp_valid");
            end else begin
                e = rsp_q.pop_front();
                check("rsp_rdata",   bif.rsp_rdata, e.rdata);
                check("rsp_err",     bif.rsp_err,   e.err);
                check("rsp_latency", cyc - e.accept + 1, e.lat);
            end
        end
    end

    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int waits, input logic [31:0] rd,
                         input bit want_rsp);
        int   guard;
        int   n;
        int   off;
        bit   legal;
        bus_t b;
        rsp_t r;
        guard = 0;
        @(negedge clk);
        while ((!bif.req_ready || rsp_q.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            fail_now("req_ready_timeout");
            return;
        end
        legal = (f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
        n     = 1 << f3[1:0];
        off   = int'(addr[1:0]);
        r.accept = cyc + 1;
        if (!legal) begin
            r.err = 2'b11; r.rdata = 32'h0; r.lat = 1;
        end else if ((off % n) != 0) begin
            r.err = 2'b01; r.rdata = 32'h0; r.lat = 1;
        end else begin
            b.addr  = addr & 32'hFFFF_FFFC;
            b.be    = 4'b0000;
            b.wdata = 32'h0;
            for (int i = 0; i < n; i++) begin
                b.be[off + i] = 1'b1;
                if (we) b.wdata |= ((wd >> (8 * i)) & 32'hFF) << (8 * (off + i));
            end
            b.we    = we;
            b.waits = waits;
            b.rd    = rd;
            if (waits >= 16) begin
                b.len = 16; r.err = 2'b10; r.rdata = 32'h0; r.lat = 17;
            end else begin
                b.len = waits + 1; r.err = 2'b00; r.lat = waits + 2;
                r.rdata = we ? 32'h0 : model_load(rd, off, n, f3[2]);
            end
            bus_q.push_back(b);
        end
        if (want_rsp) rsp_q.push_back(r);
        bif.req_valid  = 1'b1;
        bif.req_we     = we;
        bif.req_funct3 = f3;
        bif.req_addr   = addr;
        bif.req_wdata  = wd;
        @(negedge clk);
        bif.req_valid  = 1'b0;
        bif.req_addr   = $urandom;
        bif.req_wdata  = $urandom;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) fail_now("drain_timeout");
    endtask

    initial begin
        reset          = 1'b0;
        bif.req_valid  = 1'b0;
        bif.req_we     = 1'b0;
        bif.req_funct3 = 3'd0;
        bif.req_addr   = 32'h0;
        bif.req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busReq",    bif.busReq,    1'b0);
        check("rst_busWe",     bif.busWe,     1'b0);
        check("rst_busAddr",   bif.busAddr,   32'h0);
        check("rst_busBE",     bif.busBE,     4'h0);
        check("rst_busWData",  bif.busWData,  32'h0);
        check("rst_rsp_valid", bif.rsp_valid, 1'b0);
        check("rst_rsp_rdata", bif.rsp_rdata, 32'h0);
        check("rst_rsp_err",   bif.rsp_err,   2'b00);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", bif.req_ready, 1'b1);

        // Directed cases from the block's reference scenarios.
        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, 1'b1);
        issue(1'b1, 3'b000, 32'h103, 32'h123456A5, 0, 32'h0, 1'b1);
        issue(1'b0, 3'b000, 32'h102, 32'h0, 3, 32'h12F45678, 1'b1);
        issue(1'b0, 3'b100, 32'h102, 32'h0, 3, 32'h12F45678, 1'b1);
        issue(1'b0, 3'b001, 32'h102, 32'h0, 3, 32'h12F45678, 1'b1);
        issue(1'b0, 3'b010, 32'h106, 32'h0, 0, 32'h0, 1'b1);
        issue(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1'b1);
        issue(1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0, 1'b1);
        drain();
`ifdef LSU_TIMEOUT_EN
        issue(1'b0, 3'b010, 32'h140, 32'h0, 1 << 30, 32'h0, 1'b1);
        drain();
        @(negedge clk);
        check("timeout_req_ready", bif.req_ready, 1'b1);
`endif

        // Reset in the second ACCESS cycle aborts the transfer silently.
        issue(1'b0, 3'b010, 32'h200, 32'h0, 1 << 30, 32'h0, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busReq",    bif.busReq,    1'b0);
        check("abort_rsp_valid", bif.rsp_valid, 1'b0);
        check("abort_busBE",     bif.busBE,     4'h0);
        repeat (2) @(negedge clk);
        bus_q.delete();
        reset = 1'b1;
        @(negedge clk);
        check("abort_req_ready", bif.req_ready, 1'b1);
        issue(1'b1, 3'b010, 32'h100, 32'hCAFEF00D, 1, 32'h0, 1'b1);
        drain();

        // Randomised mix of sizes, offsets, legal/illegal codes and wait states.
        for (int k = 0; k < 80; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom : (32'h100 + 32'($urandom_range(0, 15)));
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                  $urandom_range(0, 4), $urandom, 1'b1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
